quadrature_decoder: RTL and testbench

- Decodes a two-channel quadrature (A/B) encoder into a one-cycle `step` pulse plus a held `upDown` direction level.
- Sits directly upstream of the team's up/down position counter. `upDown` drives its direction input; `step` qualifies its advance.
- Front end: two-flop synchronizer and per-channel glitch filter.
- Back end: x4 transition decoder with an illegal-transition error flag.

---
 rtl/quadrature_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_quadrature_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_decoder.sv
// Quadrature (A/B) encoder front end for the up/down position counter.
// Each channel is synchronized and glitch filtered, and the filtered pair is
// decoded x4 into a one-cycle step pulse plus a held direction level. Two
// channels moving on the same edge is not a legal quadrature move: it raises
// the sticky error flag and the decoder resynchronizes to the new pair.
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | filters load straight from the synchronizers, prev follows
//       | them, no step or error; lasts FilterLen+2 cycles after reset
// TRACK | normal filtering and x4 decoding until the next reset

// Per-channel glitch filter: the output follows the input only once the input
// has disagreed with it for FilterLen consecutive cycles.
module quadrature_filter #(
  parameter int FilterLen = 4,
  parameter int CntWidth  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic din,
  output logic f
);

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(FilterLen - 1);

  logic [CntWidth-1:0] cnt;

  // Filtered value and disagreement counter; load bypasses the qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f   <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      f   <= din;
      cnt <= '0;
    end else if (din != f) begin
      if (cnt == CntLast) begin
        f   <= din;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

module quadrature_decoder #(
  parameter int FilterLen = 4,
  parameter int CntWidth  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic errClr,
  output logic step,
  output logic upDown,
  output logic error
);

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // initCnt must reach FilterLen+1, which is at most 256.
  localparam logic [8:0] InitLast = 9'(FilterLen + 1);

  state_t     state;
  state_t     stateNxt;
  logic [8:0] initCnt;

  logic       aS1, aS2;
  logic       bS1, bS2;
  logic       fa, fb;
  logic [1:0] cur;
  logic [1:0] prev;
  logic [1:0] posDiff;
  logic       moveFwd;
  logic       moveRev;
  logic       moveIll;
  logic       loadFilt;

  // Position of a pair along the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] quad_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   quad_pos = 2'd0;
      2'b10:   quad_pos = 2'd1;
      2'b11:   quad_pos = 2'd2;
      default: quad_pos = 2'd3;
    endcase
  endfunction

  // Two-flop synchronizers for the asynchronous encoder channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aS1 <= 1'b0;
      aS2 <= 1'b0;
      bS1 <= 1'b0;
      bS2 <= 1'b0;
    end else begin
      aS1 <= a;
      aS2 <= aS1;
      bS1 <= b;
      bS2 <= bS1;
    end
  end

  assign loadFilt = (state == INIT);

  quadrature_filter #(
    .FilterLen (FilterLen),
    .CntWidth  (CntWidth)
  ) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .load (loadFilt),
    .din  (aS2),
    .f    (fa)
  );

  quadrature_filter #(
    .FilterLen (FilterLen),
    .CntWidth  (CntWidth)
  ) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .load (loadFilt),
    .din  (bS2),
    .f    (fb)
  );

  assign cur = {fa, fb};

  // Classify the move from prev to cur by distance along the forward cycle.
  always_comb begin
    posDiff = quad_pos(cur) - quad_pos(prev);
    moveFwd = (posDiff == 2'd1);
    moveRev = (posDiff == 2'd3);
    moveIll = (posDiff == 2'd2);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= stateNxt;
    end
  end

  // Next state: leave INIT once the filters and prev have settled.
  always_comb begin
    stateNxt = state;
    case (state)
      INIT:    if (initCnt == InitLast) stateNxt = TRACK;
      TRACK:   stateNxt = TRACK;
      default: stateNxt = INIT;
    endcase
  end

  // INIT duration counter; it parks at its last value once TRACK is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      initCnt <= '0;
    end else if (state == INIT && initCnt != InitLast) begin
      initCnt <= initCnt + 1'b1;
    end
  end

  // prev follows the filtered pair every cycle, so an illegal jump resyncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 2'b00;
    end else begin
      prev <= cur;
    end
  end

  // Registered step/direction; upDown moves only together with step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step   <= 1'b0;
      upDown <= 1'b0;
    end else begin
      step <= 1'b0;
      if (state == TRACK && (moveFwd || moveRev)) begin
        step   <= 1'b1;
        upDown <= moveFwd;
      end
    end
  end

  // Sticky error; a new illegal move outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (state == TRACK && moveIll) begin
      error <= 1'b1;
    end else if (errClr) begin
      error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder with FilterLen = 4.
module tb_quadrature_decoder;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic errClr;
  logic step;
  logic upDown;
  logic error;

  int checks;
  int fails;

  int   steps;
  int   first_k;
  int   last_k;
  int   dbl;
  int   stray;
  logic first_ud;
  logic last_ud;

  quadrature_decoder #(
    .FilterLen (4),
    .CntWidth  (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .errClr (errClr),
    .step   (step),
    .upDown (upDown),
    .error  (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Run n clock cycles, sampling at each falling edge, and gather step stats.
  // Cycle k=1 is the first rising edge after the call.
  task automatic watch(input int n);
    logic pstep;
    logic pud;
    steps   = 0;
    first_k = 0;
    last_k  = 0;
    dbl     = 0;
    stray   = 0;
    pstep   = step;
    pud     = upDown;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (step === 1'b1) begin
        steps++;
        if (first_k == 0) begin
          first_k  = k;
          first_ud = upDown;
        end
        last_k  = k;
        last_ud = upDown;
        if (pstep === 1'b1) dbl++;
      end else if (upDown !== pud) begin
        stray++;
      end
      pstep = step;
      pud   = upDown;
    end
  endtask

  task automatic test_reset;
    a = 1'b1;
    b = 1'b1;
    errClr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({step, upDown, error} !== 3'b000) begin fails++; $display("FAIL rst_outputs: got %b want 000", {step, upDown, error}); end
    rst = 1'b0;
    watch(5);
    checks++; if (dut.state !== 1'b0) begin fails++; $display("FAIL rst_init_len5: state got %b want INIT(0)", dut.state); end
    checks++; if (steps !== 0) begin fails++; $display("FAIL rst_init_step: got %0d steps want 0", steps); end
    watch(1);
    checks++; if (dut.state !== 1'b1) begin fails++; $display("FAIL rst_init_len6: state got %b want TRACK(1)", dut.state); end
    watch(20);
    checks++; if (steps !== 0) begin fails++; $display("FAIL rst_idle_step: got %0d steps want 0", steps); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL rst_idle_error: got %b want 0", error); end
    checks++; if (upDown !== 1'b0) begin fails++; $display("FAIL rst_idle_updown: got %b want 0", upDown); end
    checks++; if (dut.prev !== 2'b11) begin fails++; $display("FAIL rst_prev: got %b want 11", dut.prev); end
  endtask

  task automatic test_forward;
    logic [1:0] seq [4];
    seq[0] = 2'b10;
    seq[1] = 2'b11;
    seq[2] = 2'b01;
    seq[3] = 2'b00;
    a = 1'b0;
    b = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch(10);
    checks++; if (steps !== 0) begin fails++; $display("FAIL fwd_init_step: got %0d want 0", steps); end
    for (int i = 0; i < 4; i++) begin
      {a, b} = seq[i];
      watch(20);
      checks++; if (steps !== 1) begin fails++; $display("FAIL fwd_steps[%0d]: got %0d want 1", i, steps); end
      checks++; if (first_k !== 7) begin fails++; $display("FAIL fwd_latency[%0d]: got %0d want 7", i, first_k); end
      checks++; if (first_ud !== 1'b1) begin fails++; $display("FAIL fwd_updown[%0d]: got %b want 1", i, first_ud); end
      checks++; if (stray !== 0) begin fails++; $display("FAIL fwd_stray[%0d]: got %0d want 0", i, stray); end
    end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL fwd_error: got %b want 0", error); end
  endtask

  task automatic test_reverse;
    {a, b} = 2'b01;
    watch(20);
    checks++; if (steps !== 1) begin fails++; $display("FAIL rev_steps: got %0d want 1", steps); end
    checks++; if (first_k !== 7) begin fails++; $display("FAIL rev_latency: got %0d want 7", first_k); end
    checks++; if (first_ud !== 1'b0) begin fails++; $display("FAIL rev_updown: got %b want 0", first_ud); end
    watch(30);
    checks++; if (steps !== 0) begin fails++; $display("FAIL rev_idle_steps: got %0d want 0", steps); end
    checks++; if (upDown !== 1'b0) begin fails++; $display("FAIL rev_idle_updown: got %b want 0", upDown); end
  endtask

  task automatic test_glitch;
    {a, b} = 2'b00;
    watch(20);
    checks++; if (steps !== 1 || first_ud !== 1'b1) begin fails++; $display("FAIL glitch_setup: got %0d steps ud %b want 1 step ud 1", steps, first_ud); end
    a = 1'b1;
    watch(3);
    checks++; if (steps !== 0) begin fails++; $display("FAIL glitch3_during: got %0d want 0", steps); end
    a = 1'b0;
    watch(20);
    checks++; if (steps !== 0) begin fails++; $display("FAIL glitch3_steps: got %0d want 0", steps); end
    checks++; if (dut.prev !== 2'b00) begin fails++; $display("FAIL glitch3_filtered: got %b want 00", dut.prev); end
    a = 1'b1;
    watch(4);
    checks++; if (steps !== 0) begin fails++; $display("FAIL glitch4_during: got %0d want 0", steps); end
    a = 1'b0;
    watch(30);
    checks++; if (steps !== 2) begin fails++; $display("FAIL glitch4_steps: got %0d want 2", steps); end
    checks++; if (first_k !== 3 || first_ud !== 1'b1) begin fails++; $display("FAIL glitch4_up: got k=%0d ud=%b want k=3 ud=1", first_k, first_ud); end
    checks++; if (last_k !== 7 || last_ud !== 1'b0) begin fails++; $display("FAIL glitch4_down: got k=%0d ud=%b want k=7 ud=0", last_k, last_ud); end
    checks++; if (dbl !== 0) begin fails++; $display("FAIL glitch4_double: got %0d want 0", dbl); end
  endtask

  task automatic test_illegal;
    {a, b} = 2'b10;
    watch(20);
    checks++; if (steps !== 1 || first_ud !== 1'b1) begin fails++; $display("FAIL ill_setup: got %0d steps ud %b want 1 step ud 1", steps, first_ud); end
    {a, b} = 2'b01;
    watch(20);
    checks++; if (steps !== 0) begin fails++; $display("FAIL ill_steps: got %0d want 0", steps); end
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL ill_error: got %b want 1", error); end
    checks++; if (upDown !== 1'b1) begin fails++; $display("FAIL ill_updown: got %b want 1", upDown); end
    {a, b} = 2'b10;
    watch(6);
    errClr = 1'b1;
    watch(1);
    errClr = 1'b0;
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL ill_set_wins: got %b want 1", error); end
    watch(10);
    checks++; if (steps !== 0 || error !== 1'b1) begin fails++; $display("FAIL ill2_after: got %0d steps err %b want 0 steps err 1", steps, error); end
    errClr = 1'b1;
    watch(1);
    errClr = 1'b0;
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL ill_clear: got %b want 0", error); end
    watch(5);
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL ill_clear_hold: got %b want 0", error); end
  endtask

  task automatic test_reset_mid;
    {a, b} = 2'b11;
    watch(4);
    checks++; if (upDown !== 1'b1) begin fails++; $display("FAIL mid_pre_updown: got %b want 1", upDown); end
    rst = 1'b1;
    #1;
    checks++; if ({step, upDown, error} !== 3'b000) begin fails++; $display("FAIL mid_async: got %b want 000", {step, upDown, error}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch(5);
    checks++; if (dut.state !== 1'b0) begin fails++; $display("FAIL mid_init_len5: state got %b want INIT(0)", dut.state); end
    watch(1);
    checks++; if (dut.state !== 1'b1) begin fails++; $display("FAIL mid_init_len6: state got %b want TRACK(1)", dut.state); end
    watch(20);
    checks++; if (steps !== 0) begin fails++; $display("FAIL mid_idle_steps: got %0d want 0", steps); end
    {a, b} = 2'b01;
    watch(20);
    checks++; if (steps !== 1 || first_k !== 7 || first_ud !== 1'b1) begin fails++; $display("FAIL mid_resume: got %0d steps k=%0d ud=%b want 1 step k=7 ud=1", steps, first_k, first_ud); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    a      = 1'b1;
    b      = 1'b1;
    errClr = 1'b0;
    test_reset;
    test_forward;
    test_reverse;
    test_glitch;
    test_illegal;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
